// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter, fed by the baud generator. A byte is taken in over a
// valid/ready handshake and sent on tx as: one start bit (0), DATA_BITS data
// bits LSB first, an optional parity bit, then STOP_BITS stop bits (1). Every
// bit lasts one baud_tick interval. tx idles high.
//
// Compile-time option:
//   UART_TX_PARITY_EN  when defined, a parity bit is sent after the data bits
//                      (parity = ^data ^ PARITY_ODD). When undefined, no
//                      parity state or parity logic exists and PARITY_ODD
//                      has no effect.
//
// Parameters:
//   DATA_BITS   data bits per frame, 5..9
//   STOP_BITS   stop bits per frame, 1 or 2
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   baud_tick  in   one-cycle pulse per bit period
//   tx_data    in   byte to send, sampled only on accept
//   tx_valid   in   upstream holds tx_data valid
//   tx_ready   out  high while idle (combinational decode of the state)
//   tx         out  registered serial line, idle high
//   tx_busy    out  registered, high from accept until frame end
//   tx_done    out  registered one-cycle pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Elaboration-time sanity checks on the configuration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    // Bit counter saturates at DATA_BITS; it is cleared on every accept.
    localparam int                CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  BIT_MAX  = CNT_W'(DATA_BITS);
    // One-bit stop counter: value it holds during the final stop bit.
    localparam logic              STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_SEED = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    // Parity over the data word; seed 1 turns even parity into odd.
    function automatic logic parity_f(input logic [DATA_BITS-1:0] data,
                                      input logic                 seed);
        return (^data) ^ seed;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_STOP   = 3'd5
    } state_t;
`endif

    state_t                 state_q,   state_d;
    logic [DATA_BITS-1:0]   shreg_q,   shreg_d;
    logic [CNT_W-1:0]       bitcnt_q,  bitcnt_d;
    logic                   stopcnt_q, stopcnt_d;
    logic                   tx_q,      tx_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
`ifdef UART_TX_PARITY_EN
    // Parity is computed once from the accepted word so later edits of
    // tx_data cannot influence the frame in flight.
    logic                   parity_q,  parity_d;
`endif

    // Next-state and next-output decode; nothing advances without baud_tick
    // except the accept out of IDLE.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // A tick in the accept cycle is deliberately not used: the
                // frame waits in SYNC for the next tick so the start bit
                // spans a full bit period.
                if (tx_valid) begin
                    shreg_d   = tx_data;
                    bitcnt_d  = '0;
                    stopcnt_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SYNC;
`ifdef UART_TX_PARITY_EN
                    parity_d  = parity_f(tx_data, PARITY_SEED);
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end

            S_SYNC: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end else begin
                    tx_d = 1'b1;
                end
            end

            S_START: begin
                if (baud_tick) begin
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    tx_d = 1'b0;
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bitcnt_d = (bitcnt_q == BIT_MAX) ? bitcnt_q
                                                     : bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d      = 1'b1;
                        stopcnt_d = 1'b0;
                        state_d   = S_STOP;
`endif
                    end else begin
                        // Next data bit is the one that becomes shreg[0]
                        // after this shift.
                        tx_d = shreg_q[1];
                    end
                end else begin
                    tx_d = tx_q;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    tx_d      = 1'b1;
                    stopcnt_d = 1'b0;
                    state_d   = S_STOP;
                end else begin
                    tx_d = parity_q;
                end
            end
`endif

            S_STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    if (stopcnt_q == STOP_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stopcnt_d = stopcnt_q + 1'b1;
                    end
                end else begin
                    stopcnt_d = stopcnt_q;
                end
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx. Three instances share clock, reset and a
// baud_tick that pulses every 4 clocks:
//   A: 8 data bits, 1 stop, even parity
//   B: 7 data bits, 2 stops, even parity
//   C: 8 data bits, 1 stop, odd parity
// Expected frames are written out by hand as {stop(s), [parity], data, start}
// and every cycle of every bit is compared against them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int MAXS = 128;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;   // bits per frame for both A and B
    localparam logic [15:0] FR_55  = {5'b0, 1'b1, 1'b0, 8'h55, 1'b0};
    localparam logic [15:0] FR_A3E = {5'b0, 1'b1, 1'b0, 8'hA3, 1'b0};
    localparam logic [15:0] FR_A3O = {5'b0, 1'b1, 1'b1, 8'hA3, 1'b0};
    localparam logic [15:0] FR_01  = {5'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    localparam logic [15:0] FR_80  = {5'b0, 1'b1, 1'b1, 8'h80, 1'b0};
    localparam logic [15:0] FR_3C  = {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
    localparam logic [15:0] FR_FF  = {5'b0, 1'b1, 1'b0, 8'hFF, 1'b0};
    localparam logic [15:0] FR_7F  = {5'b0, 2'b11, 1'b1, 7'h7F, 1'b0};
`else
    localparam int NB = 10;
    localparam logic [15:0] FR_55  = {6'b0, 1'b1, 8'h55, 1'b0};
    localparam logic [15:0] FR_A3E = {6'b0, 1'b1, 8'hA3, 1'b0};
    localparam logic [15:0] FR_A3O = {6'b0, 1'b1, 8'hA3, 1'b0};
    localparam logic [15:0] FR_01  = {6'b0, 1'b1, 8'h01, 1'b0};
    localparam logic [15:0] FR_80  = {6'b0, 1'b1, 8'h80, 1'b0};
    localparam logic [15:0] FR_3C  = {6'b0, 1'b1, 8'h3C, 1'b0};
    localparam logic [15:0] FR_FF  = {6'b0, 1'b1, 8'hFF, 1'b0};
    localparam logic [15:0] FR_7F  = {6'b0, 2'b11, 7'h7F, 1'b0};
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic [7:0] c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_ready, b_tx, b_busy, b_done;
    logic       c_ready, c_tx, c_busy, c_done;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut_a (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(a_data),
        .tx_valid(a_valid), .tx_ready(a_ready), .tx(a_tx), .tx_busy(a_busy),
        .tx_done(a_done)
    );

    uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut_b (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(b_data),
        .tx_valid(b_valid), .tx_ready(b_ready), .tx(b_tx), .tx_busy(b_busy),
        .tx_done(b_done)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut_c (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(c_data),
        .tx_valid(c_valid), .tx_ready(c_ready), .tx(c_tx), .tx_busy(c_busy),
        .tx_done(c_done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   phase    = 0;
    logic last_tick;

    logic s_tx   [MAXS];
    logic s_busy [MAXS];
    logic s_done [MAXS];
    logic s_rdy  [MAXS];
    logic s_tick [MAXS];

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: baud_tick high on every 4th cycle, sample 1 ns after posedge.
    task automatic cyc();
        baud_tick = (phase == 0);
        last_tick = baud_tick;
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
    endtask

    // Read a captured sample; out-of-range indices read as X.
    function automatic logic smp(input int sel, input int i);
        if (i < 0 || i >= MAXS) return 1'bx;
        case (sel)
            0:       return s_tx[i];
            1:       return s_busy[i];
            2:       return s_done[i];
            3:       return s_rdy[i];
            default: return s_tick[i];
        endcase
    endfunction

    // Run n cycles on one DUT, recording its outputs. Cycle 0 is the accept.
    // mode 0: drop valid after accept; mode 1: hold A valid for a second
    // accept (data switched to 0x80); mode 2: toggle B data every cycle.
    task automatic capture(input int which, input int n, input int mode);
        for (int k = 0; k < MAXS; k++) begin
            s_tx[k] = 1'bx; s_busy[k] = 1'bx; s_done[k] = 1'bx;
            s_rdy[k] = 1'bx; s_tick[k] = 1'bx;
        end
        for (int k = 0; k < n; k++) begin
            cyc();
            s_tick[k] = last_tick;
            case (which)
                0:       begin s_tx[k] = a_tx; s_busy[k] = a_busy; s_done[k] = a_done; s_rdy[k] = a_ready; end
                1:       begin s_tx[k] = b_tx; s_busy[k] = b_busy; s_done[k] = b_done; s_rdy[k] = b_ready; end
                default: begin s_tx[k] = c_tx; s_busy[k] = c_busy; s_done[k] = c_done; s_rdy[k] = c_ready; end
            endcase
            if (mode == 1) begin
                if (k == 0) a_data = 8'h80;
                else if (s_done[k-1] === 1'b1) a_valid = 1'b0;
            end else begin
                if (k == 0) begin a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; end
                if (mode == 2) b_data = ~b_data;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    endtask

    // Check one frame whose accept is at capture index base.
    task automatic check_frame(input string tag, input int base,
                               input logic [15:0] fr, input int nb,
                               output int fall, output int done);
        fall = MAXS;
        for (int k = base + 1; k < MAXS; k++)
            if (s_tick[k] === 1'b1 && fall == MAXS) fall = k;
        check_eq({tag, " busy@accept"},  smp(1, base), 32'd1);
        check_eq({tag, " ready@accept"}, smp(3, base), 32'd0);
        for (int k = base; k < fall && k < MAXS; k++)
            check_eq($sformatf("%s idle-high@%0d", tag, k), smp(0, k), 32'd1);
        for (int j = 0; j < 4 * nb; j++)
            check_eq($sformatf("%s bit%0d cyc%0d", tag, j / 4, j % 4),
                     smp(0, fall + j), {31'd0, fr[j / 4]});
        done = fall + 4 * nb;
        check_eq({tag, " done-before"}, smp(2, done - 1), 32'd0);
        check_eq({tag, " done"},        smp(2, done),     32'd1);
        check_eq({tag, " done-after"},  smp(2, done + 1), 32'd0);
        check_eq({tag, " busy-last"},   smp(1, done - 1), 32'd1);
        check_eq({tag, " busy-end"},    smp(1, done),     32'd0);
        check_eq({tag, " ready-end"},   smp(3, done),     32'd1);
        check_eq({tag, " tx-end"},      smp(0, done),     32'd1);
    endtask

    // Hard limit in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        int   f1, d1, f2, d2;
        logic seen_done, seen_low;

        reset = 1'b1; baud_tick = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_data = 8'h00; b_data = 7'h00; c_data = 8'h00;

        // Reset state.
        cyc(); cyc();
        check_eq("rst tx",    a_tx,    32'd1);
        check_eq("rst busy",  a_busy,  32'd0);
        check_eq("rst done",  a_done,  32'd0);
        reset = 1'b0;
        cyc();
        check_eq("rst ready", a_ready, 32'd1);
        check_eq("rst b tx",  b_tx,    32'd1);
        check_eq("rst c rdy", c_ready, 32'd1);

        // 1: 0x55, no parity unless compiled in.
        a_data = 8'h55; a_valid = 1'b1;
        capture(0, 64, 0);
        check_frame("t1", 0, FR_55, NB, f1, d1);

        // 2: 0xA3 even (A) then odd (C).
        a_data = 8'hA3; a_valid = 1'b1;
        capture(0, 64, 0);
        check_frame("t2e", 0, FR_A3E, NB, f1, d1);
        c_data = 8'hA3; c_valid = 1'b1;
        capture(2, 64, 0);
        check_frame("t2o", 0, FR_A3O, NB, f1, d1);

        // 3: back-to-back 0x01 then 0x80 with valid held.
        a_data = 8'h01; a_valid = 1'b1;
        capture(0, 110, 1);
        check_frame("t3a", 0, FR_01, NB, f1, d1);
        check_frame("t3b", d1 + 1, FR_80, NB, f2, d2);
        check_eq("t3 gap", f2 - d1, 32'd4);

        // 4: accept in the same cycle as a tick.
        for (int i = 0; i < 4 && phase != 0; i++) cyc();
        a_data = 8'h3C; a_valid = 1'b1;
        capture(0, 64, 0);
        check_eq("t4 tick@accept", smp(4, 0), 32'd1);
        check_frame("t4", 0, FR_3C, NB, f1, d1);
        check_eq("t4 latency", f1, 32'd4);

        // 5: reset during data bit 3, then a clean 0xFF frame.
        a_data = 8'h00; a_valid = 1'b1;
        cyc();
        a_valid = 1'b0;
        for (int i = 0; i < 16 && a_tx === 1'b1; i++) cyc();
        repeat (17) cyc();
        check_eq("t5 mid-data tx",   a_tx,   32'd0);
        check_eq("t5 mid-data busy", a_busy, 32'd1);
        reset = 1'b1;
        cyc();
        check_eq("t5 rst tx",    a_tx,    32'd1);
        check_eq("t5 rst busy",  a_busy,  32'd0);
        check_eq("t5 rst done",  a_done,  32'd0);
        check_eq("t5 rst ready", a_ready, 32'd1);
        reset = 1'b0;
        seen_done = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < 48; i++) begin
            cyc();
            seen_done = seen_done | a_done;
            seen_low  = seen_low | ~a_tx;
        end
        check_eq("t5 no done", seen_done, 32'd0);
        check_eq("t5 line idle", seen_low, 32'd0);
        a_data = 8'hFF; a_valid = 1'b1;
        capture(0, 64, 0);
        check_frame("t5", 0, FR_FF, NB, f1, d1);

        // 6: 7 data bits, 2 stops, data toggled while busy.
        b_data = 7'h7F; b_valid = 1'b1;
        capture(1, 64, 2);
        check_frame("t6", 0, FR_7F, NB, f1, d1);
        for (int j = 1; j <= 8; j++)
            check_eq($sformatf("t6 stop-high-%0d", j), smp(0, d1 - j), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
